uart_tx_fifo: RTL and testbench

Transmit FIFO between the APB register interface and the UART transmitter.
- Buffers bytes written by the APB data register.
- Presents the head byte first-word-fall-through on txff_data, which the transmitter samples as its frame data.
- Pops one entry per tx_txff_rd pulse, which the transmitter asserts once at frame completion.
- Provides empty, full and level status, plus a sticky overrun flag, to the register block.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_fifo_if.sv | 40 ++++
 rtl/uart_fifo_mem.sv | 23 ++
 rtl/uart_tx_fifo.sv | 95 +++++++++
 tb/tb_uart_tx_fifo.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the FIFO pointer/level type used by both TX and RX FIFOs.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_TXFF_DEPTH = 16;
  localparam int UART_TXFF_AW    = 4;

  // One extra bit over the address width: wrap bit for pointers, 0..DEPTH for levels.
  typedef logic [UART_TXFF_AW:0] uart_ptr_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// TX FIFO request/status bundle between the APB register block, the transmitter and the FIFO.
// apb_thr exists only when UART_TXFF_THR_EN is defined.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  // Requests are single-cycle strobes with no ready: a push is taken unless the FIFO is full
  // with no pop that cycle (then dropped and flagged in txff_ovf); a pop on empty is ignored.
  logic              apb_wr;
  logic [DATA_W-1:0] apb_wdata;
  logic              tx_txff_rd;
  logic              apb_flush;
  logic              apb_ovf_clr;
`ifdef UART_TXFF_THR_EN
  logic [ADDR_W:0]   apb_thr;
`endif
  logic [DATA_W-1:0] txff_data;
  logic              txff_empty;
  logic              txff_full;
  logic [ADDR_W:0]   txff_level;
  logic              txff_ovf;
  logic              txff_thr_irq;

  modport master (
    output apb_wr, apb_wdata, tx_txff_rd, apb_flush, apb_ovf_clr,
`ifdef UART_TXFF_THR_EN
    output apb_thr,
`endif
    input  txff_data, txff_empty, txff_full, txff_level, txff_ovf, txff_thr_irq
  );

  modport slave (
    input  apb_wr, apb_wdata, tx_txff_rd, apb_flush, apb_ovf_clr,
`ifdef UART_TXFF_THR_EN
    input  apb_thr,
`endif
    output txff_data, txff_empty, txff_full, txff_level, txff_ovf, txff_thr_irq
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DW register array: synchronous write, asynchronous read. Contents are not reset.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO, first-word-fall-through, with sticky overrun and flush.
// Optional threshold interrupt compiled in with UART_TXFF_THR_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_TXFF_DEPTH,
  parameter int ADDR_W = UART_TXFF_AW,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic            pclk,
  input  logic            prst_n,
  uart_tx_fifo_if.slave   bus
);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              thr_irq_q, thr_irq_d;
  logic [ADDR_W:0]   level;
  logic              empty, full;
  logic              pop_ok, push_ok, overrun, mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Status comes only from the registered pointers, never from the request inputs.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A pop frees the head slot this cycle, so a full FIFO can still take a push alongside it.
  assign pop_ok  = bus.tx_txff_rd && !empty;
  assign push_ok = bus.apb_wr && (!full || pop_ok);
  assign overrun = bus.apb_wr && full && !pop_ok && !bus.apb_flush;
  assign mem_we  = push_ok && !bus.apb_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (bus.apb_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (bus.apb_ovf_clr) ovf_d = 1'b0;
    if (overrun)         ovf_d = 1'b1;
  end

`ifdef UART_TXFF_THR_EN
  always_comb begin
    thr_irq_d = (bus.apb_thr != '0) && (level <= bus.apb_thr);
  end
`else
  always_comb begin
    thr_irq_d = 1'b0;
  end
`endif

  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      thr_irq_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      thr_irq_q <= thr_irq_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_mem (
    .clk   (pclk),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (bus.apb_wdata),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  assign bus.txff_data    = empty ? '0 : mem_rdata;
  assign bus.txff_empty   = empty;
  assign bus.txff_full    = full;
  assign bus.txff_level   = level;
  assign bus.txff_ovf     = ovf_q;
  assign bus.txff_thr_irq = thr_irq_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo; threshold test runs when UART_TXFF_THR_EN is defined.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic pclk;
  logic prst_n;
  int   n_chk;
  int   n_fail;

  uart_tx_fifo_if #(.DATA_W(UART_DATA_W), .ADDR_W(UART_TXFF_AW)) bus ();

  uart_tx_fifo u_dut (
    .pclk   (pclk),
    .prst_n (prst_n),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [7:0] d, input logic rd,
                       input logic fl, input logic clr);
    bus.apb_wr      = wr;
    bus.apb_wdata   = d;
    bus.tx_txff_rd  = rd;
    bus.apb_flush   = fl;
    bus.apb_ovf_clr = clr;
    tick();
    bus.apb_wr      = 1'b0;
    bus.tx_txff_rd  = 1'b0;
    bus.apb_flush   = 1'b0;
    bus.apb_ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    prst_n = 1'b0;
    repeat (2) tick();
    n_chk++; if (bus.txff_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", bus.txff_empty); end
    n_chk++; if (bus.txff_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b exp=0", bus.txff_full); end
    n_chk++; if (bus.txff_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", bus.txff_level); end
    n_chk++; if (bus.txff_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%0b exp=0", bus.txff_ovf); end
    n_chk++; if (bus.txff_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", bus.txff_data); end
    n_chk++; if (bus.txff_thr_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%0b exp=0", bus.txff_thr_irq); end
    prst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.txff_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", bus.txff_data); end
    n_chk++; if (bus.txff_empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%0b exp=0", bus.txff_empty); end
    n_chk++; if (bus.txff_level !== 5'd1) begin n_fail++; $display("FAIL single_level got=%0d exp=1", bus.txff_level); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_chk++; if (bus.txff_empty !== 1'b1) begin n_fail++; $display("FAIL single_pop_empty got=%0b exp=1", bus.txff_empty); end
    n_chk++; if (bus.txff_data !== 8'h00) begin n_fail++; $display("FAIL single_pop_data got=%h exp=00", bus.txff_data); end
    // Pop on empty must be ignored.
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_chk++; if (bus.txff_level !== 5'd0) begin n_fail++; $display("FAIL pop_on_empty_level got=%0d exp=0", bus.txff_level); end
  endtask

  task automatic test_fill_ovf();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.txff_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%0b exp=1", bus.txff_full); end
    n_chk++; if (bus.txff_level !== 5'd16) begin n_fail++; $display("FAIL fill_level got=%0d exp=16", bus.txff_level); end
    n_chk++; if (bus.txff_ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pre got=%0b exp=0", bus.txff_ovf); end
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.txff_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%0b exp=1", bus.txff_ovf); end
    n_chk++; if (bus.txff_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got=%0d exp=16", bus.txff_level); end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (bus.txff_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, bus.txff_data, 8'(i)); end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    n_chk++; if (bus.txff_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%0b exp=1", bus.txff_empty); end
    n_chk++; if (bus.txff_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%0b exp=1", bus.txff_ovf); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_chk++; if (bus.txff_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%0b exp=0", bus.txff_ovf); end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp_data;
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    n_chk++; if (bus.txff_level !== 5'd16) begin n_fail++; $display("FAIL full_simul_level got=%0d exp=16", bus.txff_level); end
    n_chk++; if (bus.txff_full !== 1'b1) begin n_fail++; $display("FAIL full_simul_full got=%0b exp=1", bus.txff_full); end
    n_chk++; if (bus.txff_ovf !== 1'b0) begin n_fail++; $display("FAIL full_simul_ovf got=%0b exp=0", bus.txff_ovf); end
    for (int i = 1; i <= 16; i++) begin
      exp_data = (i == 16) ? 8'h55 : 8'(i);
      n_chk++; if (bus.txff_data !== exp_data) begin n_fail++; $display("FAIL full_simul_data[%0d] got=%h exp=%h", i, bus.txff_data, exp_data); end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    n_chk++; if (bus.txff_empty !== 1'b1) begin n_fail++; $display("FAIL full_simul_empty got=%0b exp=1", bus.txff_empty); end
  endtask

  task automatic test_empty_simul();
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    n_chk++; if (bus.txff_level !== 5'd1) begin n_fail++; $display("FAIL empty_simul_level got=%0d exp=1", bus.txff_level); end
    n_chk++; if (bus.txff_data !== 8'h3C) begin n_fail++; $display("FAIL empty_simul_data got=%h exp=3c", bus.txff_data); end
    for (int i = 0; i < 15; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    n_chk++; if (bus.txff_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%0b exp=1", bus.txff_ovf); end
    n_chk++; if (bus.txff_data !== 8'h3C) begin n_fail++; $display("FAIL ovf_head_data got=%h exp=3c", bus.txff_data); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_chk++; if (bus.txff_empty !== 1'b1) begin n_fail++; $display("FAIL flush_from_full got=%0b exp=1", bus.txff_empty); end
    n_chk++; if (bus.txff_ovf !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_ovf got=%0b exp=1", bus.txff_ovf); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.txff_level !== 5'd5) begin n_fail++; $display("FAIL flush_pre_level got=%0d exp=5", bus.txff_level); end
    drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    n_chk++; if (bus.txff_level !== 5'd0) begin n_fail++; $display("FAIL flush_level got=%0d exp=0", bus.txff_level); end
    n_chk++; if (bus.txff_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got=%0b exp=1", bus.txff_empty); end
    n_chk++; if (bus.txff_data !== 8'h00) begin n_fail++; $display("FAIL flush_data got=%h exp=00", bus.txff_data); end
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.txff_data !== 8'h77) begin n_fail++; $display("FAIL post_flush_data got=%h exp=77", bus.txff_data); end
    n_chk++; if (bus.txff_level !== 5'd1) begin n_fail++; $display("FAIL post_flush_level got=%0d exp=1", bus.txff_level); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.txff_ovf !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ovf got=%0b exp=1", bus.txff_ovf); end
    prst_n = 1'b0;
    drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    n_chk++; if (bus.txff_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty got=%0b exp=1", bus.txff_empty); end
    n_chk++; if (bus.txff_full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_full got=%0b exp=0", bus.txff_full); end
    n_chk++; if (bus.txff_level !== 5'd0) begin n_fail++; $display("FAIL mid_rst_level got=%0d exp=0", bus.txff_level); end
    n_chk++; if (bus.txff_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got=%0b exp=0", bus.txff_ovf); end
    n_chk++; if (bus.txff_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got=%h exp=00", bus.txff_data); end
    prst_n = 1'b1;
    tick();
  endtask

`ifdef UART_TXFF_THR_EN
  task automatic test_thr();
    bus.apb_thr = 5'd2;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    tick();
    n_chk++; if (bus.txff_thr_irq !== 1'b0) begin n_fail++; $display("FAIL thr_level4 got=%0b exp=0", bus.txff_thr_irq); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_chk++; if (bus.txff_thr_irq !== 1'b0) begin n_fail++; $display("FAIL thr_same_cycle got=%0b exp=0", bus.txff_thr_irq); end
    tick();
    n_chk++; if (bus.txff_thr_irq !== 1'b1) begin n_fail++; $display("FAIL thr_level2 got=%0b exp=1", bus.txff_thr_irq); end
    bus.apb_thr = 5'd0;
    tick();
    n_chk++; if (bus.txff_thr_irq !== 1'b0) begin n_fail++; $display("FAIL thr_zero got=%0b exp=0", bus.txff_thr_irq); end
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    prst_n          = 1'b0;
    bus.apb_wr      = 1'b0;
    bus.apb_wdata   = 8'h00;
    bus.tx_txff_rd  = 1'b0;
    bus.apb_flush   = 1'b0;
    bus.apb_ovf_clr = 1'b0;
`ifdef UART_TXFF_THR_EN
    bus.apb_thr     = 5'd0;
`endif
    test_reset();
    test_single();
    test_fill_ovf();
    test_full_simul();
    test_empty_simul();
    test_flush();
    test_reset_mid();
`ifdef UART_TXFF_THR_EN
    test_thr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
